// File: rtl/player_ctrl_pkg.sv
// Shared constants, shoot FSM encoding and the saturating axis-step helper
// used by the player controller.
package player_ctrl_pkg;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int PLAYER_W_DEF = 32;
  localparam int PLAYER_H_DEF = 32;

  typedef enum logic {
    ST_READY   = 1'b0,
    ST_COOLING = 1'b1
  } shoot_state_e;

  // Move one axis by step, clamped to [0, max_pos]; opposing keys cancel.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dec,
                                           input logic inc, input logic [9:0] step,
                                           input logic [9:0] max_pos);
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (dec && !inc) begin
      step_axis = (pos < step) ? 10'd0 : pos - step;
    end else if (inc && !dec) begin
      step_axis = (sum > {1'b0, max_pos}) ? max_pos : sum[9:0];
    end else begin
      step_axis = pos;
    end
  endfunction

endpackage

// File: rtl/player_ctrl_bullet_slot.sv
// One bullet slot: load beats kill, kill beats the per-frame advance/retire.
module bullet_slot
  import player_ctrl_pkg::*;
#(
  parameter int BULLET_STEP = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic       kill_i,
  input  logic       adv_i,
  output logic       valid_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o
);

  logic       valid_q, valid_d;
  logic [9:0] x_q, x_d, y_q, y_d;

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    if (load_i) begin
      valid_d = 1'b1;
      x_d     = x_i;
      y_d     = y_i;
    end else if (kill_i) begin
      valid_d = 1'b0;
    end else if (adv_i && valid_q) begin
      if (y_q < 10'(BULLET_STEP)) begin
        valid_d = 1'b0;
      end else begin
        y_d = y_q - 10'(BULLET_STEP);
      end
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;

endmodule

// File: rtl/player_ctrl.sv
// Player movement, shoot cooldown FSM and lowest-free bullet allocation,
// all advancing on frame_tick.
module player_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int PLAYER_W    = PLAYER_W_DEF,
  parameter int PLAYER_H    = PLAYER_H_DEF,
  parameter int STEP        = 4,
  parameter int BULLET_STEP = 8,
  parameter int NUM_BULLETS = 4,
  parameter int COOLDOWN    = 8,
  parameter int X_INIT      = 304,
  parameter int Y_INIT      = 440
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic [3:0]                nums,
  input  logic                      shoot,
  input  logic [NUM_BULLETS-1:0]    bullet_kill,
  output logic [9:0]                player_x,
  output logic [9:0]                player_y,
  output logic [NUM_BULLETS-1:0]    bullet_valid,
  output logic [10*NUM_BULLETS-1:0] bullet_x,
  output logic [10*NUM_BULLETS-1:0] bullet_y,
  output logic                      fire_pulse
);

  localparam logic [9:0] MAX_X = 10'(SCREEN_W - PLAYER_W);
  localparam logic [9:0] MAX_Y = 10'(SCREEN_H - PLAYER_H);

  shoot_state_e           state_q;
  logic [7:0]             cd_q;
  logic                   fire_q;
  logic [9:0]             px_q, px_d, py_q, py_d;
  logic [NUM_BULLETS-1:0] valid_s, alloc_s, load_s;
  logic                   fire_s;

  // Lowest-index free slot, judged on the pre-tick valid vector only.
  always_comb begin
    alloc_s = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!valid_s[i] && (alloc_s == '0)) begin
        alloc_s[i] = 1'b1;
      end else begin
        alloc_s[i] = alloc_s[i];
      end
    end
    fire_s = frame_tick && (state_q == ST_READY) && shoot && (alloc_s != '0);
    load_s = fire_s ? alloc_s : '0;
  end

  always_comb begin
    if (frame_tick) begin
      px_d = step_axis(px_q, nums[DIR_LEFT], nums[DIR_RIGHT], 10'(STEP), MAX_X);
      py_d = step_axis(py_q, nums[DIR_UP], nums[DIR_DOWN], 10'(STEP), MAX_Y);
    end else begin
      px_d = px_q;
      py_d = py_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_READY;
      cd_q    <= 8'd0;
      fire_q  <= 1'b0;
      px_q    <= 10'(X_INIT);
      py_q    <= 10'(Y_INIT);
    end else begin
      fire_q <= fire_s;
      px_q   <= px_d;
      py_q   <= py_d;
      if (frame_tick) begin
        case (state_q)
          ST_READY: begin
            if (fire_s) begin
              state_q <= ST_COOLING;
              cd_q    <= 8'(COOLDOWN - 1);
            end
          end
          ST_COOLING: begin
            if (cd_q == 8'd0) begin
              state_q <= ST_READY;
            end else begin
              cd_q <= cd_q - 8'd1;
            end
          end
          default: state_q <= ST_READY;
        endcase
      end
    end
  end

  // New bullets launch from the pre-move sprite centre column.
  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(.BULLET_STEP(BULLET_STEP)) u_slot (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (load_s[g]),
      .x_i     (px_q + 10'(PLAYER_W / 2 - 1)),
      .y_i     (py_q),
      .kill_i  (bullet_kill[g]),
      .adv_i   (frame_tick),
      .valid_o (valid_s[g]),
      .x_o     (bullet_x[10*g +: 10]),
      .y_o     (bullet_y[10*g +: 10])
    );
  end

  assign bullet_valid = valid_s;
  assign player_x     = px_q;
  assign player_y     = py_q;
  assign fire_pulse   = fire_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with a reference model feeding a scoreboard queue.
module tb_player_ctrl;

  logic        clk, rst, frame_tick, shoot, fire_pulse;
  logic [3:0]  nums, bullet_kill, bullet_valid;
  logic [9:0]  player_x, player_y;
  logic [39:0] bullet_x, bullet_y;

  player_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .nums(nums), .shoot(shoot),
    .bullet_kill(bullet_kill), .player_x(player_x), .player_y(player_y),
    .bullet_valid(bullet_valid), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .fire_pulse(fire_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  px;
    logic [9:0]  py;
    logic [3:0]  v;
    logic [39:0] bx;
    logic [39:0] by;
    logic        f;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  int         mx, my, mcd;
  bit         mready;
  logic [3:0] mv;
  logic [9:0] mbx[4];
  logic [9:0] mby[4];

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mx = 304; my = 440; mcd = 0; mready = 1'b1; mv = 4'd0;
    for (int i = 0; i < 4; i++) begin mbx[i] = 10'd0; mby[i] = 10'd0; end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; frame_tick = 1'b0; bullet_kill = 4'd0; shoot = 1'b0; nums = 4'd0;
    #2;
    chk({tag, "_x"}, 40'(player_x), 40'd304);
    chk({tag, "_y"}, 40'(player_y), 40'd440);
    chk({tag, "_valid"}, 40'(bullet_valid), 40'd0);
    chk({tag, "_fire"}, 40'(fire_pulse), 40'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic step(input bit tk, input logic [3:0] n, input bit sh, input logic [3:0] kl);
    exp_t e;
    logic [3:0] nv;
    logic [9:0] nbx[4];
    logic [9:0] nby[4];
    bit fire;
    int slot;
    fire = 1'b0; slot = 0; nv = mv; nbx = mbx; nby = mby;
    if (tk) begin
      if (mready) begin
        if (sh && mv != 4'hF) begin
          fire = 1'b1;
          for (int i = 3; i >= 0; i--) if (!mv[i]) slot = i;
          mready = 1'b0; mcd = 7;
        end
      end else if (mcd == 0) mready = 1'b1;
      else mcd = mcd - 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (fire && i == slot) begin
        nv[i] = 1'b1; nbx[i] = 10'(mx + 15); nby[i] = 10'(my);
      end else if (kl[i]) nv[i] = 1'b0;
      else if (tk && mv[i]) begin
        if (mby[i] < 10'd8) nv[i] = 1'b0;
        else nby[i] = mby[i] - 10'd8;
      end
    end
    if (tk) begin
      if (n[1] && !n[0]) mx = (mx < 4) ? 0 : mx - 4;
      else if (n[0] && !n[1]) mx = (mx + 4 > 608) ? 608 : mx + 4;
      if (n[3] && !n[2]) my = (my < 4) ? 0 : my - 4;
      else if (n[2] && !n[3]) my = (my + 4 > 448) ? 448 : my + 4;
    end
    mv = nv; mbx = nbx; mby = nby;
    e.px = 10'(mx); e.py = 10'(my); e.v = mv; e.f = fire;
    for (int i = 0; i < 4; i++) begin e.bx[10*i +: 10] = mbx[i]; e.by[10*i +: 10] = mby[i]; end
    sbq.push_back(e);
    frame_tick = tk; nums = n; shoot = sh; bullet_kill = kl;
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("sb_px", 40'(player_x), 40'(e.px));
    chk("sb_py", 40'(player_y), 40'(e.py));
    chk("sb_valid", 40'(bullet_valid), 40'(e.v));
    chk("sb_bx", bullet_x, e.bx);
    chk("sb_by", bullet_y, e.by);
    chk("sb_fire", 40'(fire_pulse), 40'(e.f));
    frame_tick = 1'b0; bullet_kill = 4'd0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; nums = 4'd0; shoot = 1'b0; bullet_kill = 4'd0;
    #3;
    do_reset("rst0");

    for (int k = 0; k < 3; k++) step(1'b1, 4'b0001, 1'b0, 4'd0);
    chk("right3_x", 40'(player_x), 40'd316);
    chk("right3_y", 40'(player_y), 40'd440);
    step(1'b0, 4'b0001, 1'b0, 4'd0);
    do_reset("midrst");

    for (int k = 0; k < 2; k++) step(1'b1, 4'b0011, 1'b0, 4'd0);
    for (int k = 0; k < 2; k++) step(1'b1, 4'b1100, 1'b0, 4'd0);
    chk("cancel_x", 40'(player_x), 40'd304);
    chk("cancel_y", 40'(player_y), 40'd440);

    for (int k = 0; k < 75; k++) step(1'b1, 4'b0010, 1'b0, 4'd0);
    chk("left_at4", 40'(player_x), 40'd4);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b0010, 1'b0, 4'd0);
      chk("left_sat", 40'(player_x), 40'd0);
    end
    step(1'b1, 4'b0100, 1'b0, 4'd0);
    chk("down_at444", 40'(player_y), 40'd444);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b0100, 1'b0, 4'd0);
      chk("down_sat", 40'(player_y), 40'd448);
    end

    do_reset("rst_shoot");
    for (int k = 1; k <= 37; k++) begin
      step(1'b1, 4'b0000, 1'b1, 4'd0);
      chk("fire_tick", 40'(fire_pulse), 40'((k == 1 || k == 10 || k == 19 || k == 28) ? 1 : 0));
      if (k == 1) begin
        chk("b0_x", 40'(bullet_x[9:0]), 40'd319);
        chk("b0_y", 40'(bullet_y[9:0]), 40'd440);
      end
      if (k == 2) chk("b0_y_adv", 40'(bullet_y[9:0]), 40'd432);
      if (k == 19) chk("slots_012", 40'(bullet_valid), 40'h7);
      step(1'b0, 4'b0000, 1'b1, 4'd0);
      chk("fire_one_cycle", 40'(fire_pulse), 40'd0);
    end
    step(1'b1, 4'b0000, 1'b1, 4'b0100);
    chk("kill_nofire", 40'(fire_pulse), 40'd0);
    chk("kill_valid", 40'(bullet_valid), 40'hB);
    step(1'b1, 4'b0000, 1'b1, 4'd0);
    chk("refire_pulse", 40'(fire_pulse), 40'd1);
    chk("refire_valid", 40'(bullet_valid), 40'hF);
    chk("refire_y2", 40'(bullet_y[29:20]), 40'd440);

    do_reset("rst_retire");
    step(1'b1, 4'b0100, 1'b0, 4'd0);
    for (int t = 0; t <= 57; t++) begin
      step(1'b1, 4'b0000, 1'b1, 4'd0);
      if (t == 55) begin
        chk("pre_retire_y", 40'(bullet_y[9:0]), 40'd4);
        chk("pre_retire_full", 40'(bullet_valid), 40'hF);
      end
      if (t == 56) begin
        chk("retired_v0", 40'(bullet_valid[0]), 40'd0);
        chk("retire_nofire", 40'(fire_pulse), 40'd0);
      end
      if (t == 57) begin
        chk("reuse_fire", 40'(fire_pulse), 40'd1);
        chk("reuse_v0", 40'(bullet_valid[0]), 40'd1);
        chk("reuse_y0", 40'(bullet_y[9:0]), 40'd444);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
